// File: rtl/vid_pattern_gen.sv
// Video timing and test-pattern generator with a small Wishbone CSR block.
// Produces registered RGB/hsync/vsync/de with one clock of latency from the
// raster counters; pattern mode and solid colour are sampled at frame start.
module vid_pattern_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic        HS_POL   = 1'b0,
   parameter logic        VS_POL   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [23:0] out_data,
   output logic        out_hsync,
   output logic        out_vsync,
   output logic        out_de,
   input  logic [1:0]  wb_addr,
   input  logic [31:0] wb_wdata,
   output logic [31:0] wb_rdata,
   input  logic        wb_we,
   input  logic        wb_cyc,
   output logic        wb_ack
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = ($clog2(H_TOTAL) < 8) ? 8 : $clog2(H_TOTAL);
   localparam int unsigned VW      = ($clog2(V_TOTAL) < 8) ? 8 : $clog2(V_TOTAL);
   localparam int unsigned BAR_W   = H_ACTIVE / 8;
   localparam int unsigned BCW     = $clog2(BAR_W + 1);

   localparam logic [HW-1:0]  H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]  H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0]  H_ACT_LAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0]  HS_START   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]  HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]  V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]  V_ACT      = VW'(V_ACTIVE);
   localparam logic [VW-1:0]  V_ACT_LAST = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0]  VS_START   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]  VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [BCW-1:0] BAR_LAST   = BCW'(BAR_W - 1);

   typedef enum logic [2:0] {
      MODE_BARS  = 3'd0,
      MODE_SOLID = 3'd1,
      MODE_GRAD  = 3'd2,
      MODE_GRID  = 3'd3,
      MODE_CHECK = 3'd4
   } mode_e;

   logic           run_q, run_d;
   logic [HW-1:0]  h_cnt_q, h_cnt_d;
   logic [VW-1:0]  v_cnt_q, v_cnt_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;
   mode_e          mode_q, mode_d;
   logic [23:0]    color_lat_q, color_lat_d;
   logic [BCW-1:0] bar_cnt_q, bar_cnt_d;
   logic [2:0]     bar_idx_q, bar_idx_d;
   logic [2:0]     ctrl_q, ctrl_d;
   logic [23:0]    color_q, color_d;
   logic [23:0]    out_data_q, out_data_d;
   logic           out_hsync_q, out_hsync_d;
   logic           out_vsync_q, out_vsync_d;
   logic           out_de_q, out_de_d;
   logic           wb_ack_q, wb_ack_d;
   logic [31:0]    wb_rdata_q, wb_rdata_d;
   logic           frame_wrap;
   logic           active;
   logic [23:0]    pixel;
   logic [31:0]    rd_mux;

   // Raster counters; run_q holds the counters at (0,0) for the first clock
   // after reset so that (0,0) is the state of that clock, not its successor.
   always_comb begin
      run_d       = 1'b1;
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      frame_wrap  = 1'b0;
      if (run_q) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d    = '0;
               frame_wrap = 1'b1;
            end else begin
               v_cnt_d = v_cnt_q + 1'b1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
      frame_cnt_d = frame_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
      mode_d      = frame_wrap ? mode_e'(ctrl_q) : mode_q;
      color_lat_d = frame_wrap ? color_q : color_lat_q;
   end

   // Colour-bar index tracked by a sub-counter alongside h_cnt (no divider).
   always_comb begin
      bar_cnt_d = bar_cnt_q;
      bar_idx_d = bar_idx_q;
      if (run_q) begin
         if (h_cnt_q == H_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
         end else if (h_cnt_q < H_ACT) begin
            if (bar_cnt_q == BAR_LAST) begin
               bar_cnt_d = '0;
               bar_idx_d = bar_idx_q + 3'd1;
            end else begin
               bar_cnt_d = bar_cnt_q + 1'b1;
            end
         end
      end
   end

   // Pixel pattern and sync/de for the current counter state.
   always_comb begin
      active = run_q && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      pixel  = '0;
      case (mode_q)
         MODE_BARS:  pixel = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
         MODE_SOLID: pixel = color_lat_q;
         MODE_GRAD:  pixel = {h_cnt_q[7:0], v_cnt_q[7:0], frame_cnt_q[7:0]};
         MODE_GRID:  pixel = ((h_cnt_q[4:0] == 5'd0) || (v_cnt_q[4:0] == 5'd0) ||
                              (h_cnt_q == H_ACT_LAST) || (v_cnt_q == V_ACT_LAST)) ? '1 : '0;
         MODE_CHECK: pixel = (h_cnt_q[4] ^ v_cnt_q[4] ^ frame_cnt_q[5]) ? '1 : '0;
         default:    pixel = '0;
      endcase
      out_data_d  = active ? pixel : '0;
      out_de_d    = active;
      out_hsync_d = (run_q && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
      out_vsync_d = (run_q && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
   end

   // Wishbone slave: single-clock ack, read data only during ack, write on ack.
   always_comb begin
      wb_ack_d = wb_cyc && !wb_ack_q;
      case (wb_addr)
         2'd0:    rd_mux = {29'd0, ctrl_q};
         2'd1:    rd_mux = {8'd0, color_q};
         2'd2:    rd_mux = {15'd0, (v_cnt_q >= V_ACT), frame_cnt_q};
         default: rd_mux = '0;
      endcase
      wb_rdata_d = wb_ack_d ? rd_mux : '0;
      ctrl_d     = ctrl_q;
      color_d    = color_q;
      if (wb_ack_d && wb_we) begin
         if (wb_addr == 2'd0) ctrl_d = wb_wdata[2:0];
         if (wb_addr == 2'd1) color_d = wb_wdata[23:0];
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_q       <= 1'b0;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= '0;
         mode_q      <= MODE_BARS;
         color_lat_q <= '0;
         bar_cnt_q   <= '0;
         bar_idx_q   <= '0;
         ctrl_q      <= '0;
         color_q     <= '0;
         out_data_q  <= '0;
         out_hsync_q <= ~HS_POL;
         out_vsync_q <= ~VS_POL;
         out_de_q    <= 1'b0;
         wb_ack_q    <= 1'b0;
         wb_rdata_q  <= '0;
      end else begin
         run_q       <= run_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         mode_q      <= mode_d;
         color_lat_q <= color_lat_d;
         bar_cnt_q   <= bar_cnt_d;
         bar_idx_q   <= bar_idx_d;
         ctrl_q      <= ctrl_d;
         color_q     <= color_d;
         out_data_q  <= out_data_d;
         out_hsync_q <= out_hsync_d;
         out_vsync_q <= out_vsync_d;
         out_de_q    <= out_de_d;
         wb_ack_q    <= wb_ack_d;
         wb_rdata_q  <= wb_rdata_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_hsync = out_hsync_q;
   assign out_vsync = out_vsync_q;
   assign out_de    = out_de_q;
   assign wb_ack    = wb_ack_q;
   assign wb_rdata  = wb_rdata_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Bench for vid_pattern_gen: raster-position reference model checked every
// clock, CSR vector table, hand sequences for frame-boundary corner cases.
module tb_vid_pattern_gen;

   localparam int HA = 16, HFP = 2, HSW = 2, HBP = 4;
   localparam int VA = 4, VFP = 1, VSW = 1, VBP = 2;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FT = HT * VT;
   localparam logic HS_POL = 1'b0;
   localparam logic VS_POL = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] out_data;
   logic        out_hsync, out_vsync, out_de;
   logic [1:0]  wb_addr = '0;
   logic [31:0] wb_wdata = '0;
   logic [31:0] wb_rdata;
   logic        wb_we = 1'b0;
   logic        wb_cyc = 1'b0;
   logic        wb_ack;

   int checks = 0;
   int errors = 0;

   vid_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .clk(clk), .rst(rst),
      .out_data(out_data), .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
      .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
      .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   // reference model state
   bit          m_run = 0;
   int          m_pos = 0;
   int          m_frame = 0;
   logic [2:0]  m_ctrl = '0, m_mode = '0;
   logic [23:0] m_color = '0, m_lcolor = '0;
   bit          m_ack = 0;
   bit          o_valid = 0;
   int          o_x = 0, o_y = 0, o_f = 0;
   logic [23:0] e_data;
   logic        e_de, e_hs, e_vs, e_ack;
   logic [31:0] e_rdata;

   typedef struct {
      logic [1:0]  waddr;
      logic [31:0] wdata;
      logic [1:0]  raddr;
      logic [31:0] exp;
   } csr_vec_t;
   csr_vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s act=timeout exp=reached t=%0t", name, $time);
   endtask

   function automatic logic [23:0] pix(int x, int y, logic [2:0] mode, logic [23:0] col, int fr);
      case (mode)
         3'd0: return bar_rgb[x / (HA / 8)];
         3'd1: return col;
         3'd2: return {8'(x % 256), 8'(y % 256), 8'(fr % 256)};
         3'd3: return ((x % 32 == 0) || (y % 32 == 0) || x == HA - 1 || y == VA - 1) ? 24'hFFFFFF : 24'h0;
         3'd4: return ((((x / 16) + (y / 16) + (fr / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
         default: return 24'h0;
      endcase
   endfunction

   // Advance the model by one clock from the current inputs, clock the DUT, compare.
   task automatic step();
      int x, y;
      bit nack;
      logic [31:0] rd;
      if (rst) begin
         e_data = '0; e_de = 0; e_hs = ~HS_POL; e_vs = ~VS_POL; e_ack = 0; e_rdata = '0;
         m_run = 0; m_pos = 0; m_frame = 0; m_ctrl = '0; m_mode = '0;
         m_color = '0; m_lcolor = '0; m_ack = 0; o_valid = 0;
      end else begin
         x = m_pos % HT;
         y = m_pos / HT;
         if (!m_run) begin
            e_data = '0; e_de = 0; e_hs = ~HS_POL; e_vs = ~VS_POL;
         end else begin
            e_de   = (x < HA) && (y < VA);
            e_data = e_de ? pix(x, y, m_mode, m_lcolor, m_frame) : 24'h0;
            e_hs   = (x >= HA + HFP && x < HA + HFP + HSW) ? HS_POL : ~HS_POL;
            e_vs   = (y >= VA + VFP && y < VA + VFP + VSW) ? VS_POL : ~VS_POL;
         end
         o_valid = m_run; o_x = x; o_y = y; o_f = m_frame;
         nack = wb_cyc && !m_ack;
         case (wb_addr)
            2'd0: rd = {29'd0, m_ctrl};
            2'd1: rd = {8'd0, m_color};
            2'd2: rd = {15'd0, (y >= VA), 16'(m_frame)};
            default: rd = '0;
         endcase
         e_ack   = nack;
         e_rdata = nack ? rd : 32'h0;
         if (m_run) begin
            m_pos = (m_pos + 1) % FT;
            if (m_pos == 0) begin
               m_frame  = (m_frame + 1) % 65536;
               m_mode   = m_ctrl;
               m_lcolor = m_color;
            end
         end
         if (nack && wb_we) begin
            if (wb_addr == 2'd0) m_ctrl = wb_wdata[2:0];
            if (wb_addr == 2'd1) m_color = wb_wdata[23:0];
         end
         m_run = 1;
         m_ack = nack;
      end
      @(posedge clk);
      #1;
      chk("m_data", 32'(out_data), 32'(e_data));
      chk("m_de", 32'(out_de), 32'(e_de));
      chk("m_hsync", 32'(out_hsync), 32'(e_hs));
      chk("m_vsync", 32'(out_vsync), 32'(e_vs));
      chk("m_ack", 32'(wb_ack), 32'(e_ack));
      chk("m_rdata", wb_rdata, e_rdata);
   endtask

   // Step until the output just produced belongs to pixel (x,y) of frame f.
   task automatic wait_pix(input int f, input int x, input int y, input int bound);
      int n = 0;
      while (!(o_valid && o_f == f && o_x == x && o_y == y) && n < bound) begin
         step();
         n++;
      end
      if (!(o_valid && o_f == f && o_x == x && o_y == y)) timeout("wait_pix");
   endtask

   task automatic bus(input logic [1:0] a, input logic we, input logic [31:0] d, output logic [31:0] rd);
      bit got = 0;
      rd = '0;
      wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
      for (int i = 0; i < 4 && !got; i++) begin
         step();
         if (wb_ack) begin
            rd = wb_rdata;
            got = 1;
         end
      end
      if (!got) timeout("bus_ack");
      wb_cyc = 1'b0; wb_we = 1'b0;
      step();
   endtask

   initial begin
      #5_000_000;
      timeout("watchdog");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      vecs[0] = '{2'd0, 32'h0000_0005, 2'd0, 32'h0000_0005};
      vecs[1] = '{2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_0007};
      vecs[2] = '{2'd1, 32'hAABB_CCDD, 2'd1, 32'h00BB_CCDD};
      vecs[3] = '{2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
      vecs[4] = '{2'd2, 32'hFFFF_FFFF, 2'd1, 32'h00BB_CCDD};
      vecs[5] = '{2'd3, 32'h0000_0001, 2'd0, 32'h0000_0007};
      vecs[6] = '{2'd0, 32'h0000_0008, 2'd0, 32'h0000_0000};
      vecs[7] = '{2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000};

      // reset state
      rst = 1'b1;
      repeat (3) step();
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_de", 32'(out_de), 32'h0);
      chk("rst_hsync", 32'(out_hsync), 32'h1);
      chk("rst_vsync", 32'(out_vsync), 32'h1);
      chk("rst_ack", 32'(wb_ack), 32'h0);
      chk("rst_rdata", wb_rdata, 32'h0);

      // first line after release: de from clock 2, 2-pixel bars, hsync at 18..19
      rst = 1'b0;
      step();
      chk("clk1_de", 32'(out_de), 32'h0);
      chk("clk1_hsync", 32'(out_hsync), 32'h1);
      step();
      chk("clk2_de", 32'(out_de), 32'h1);
      chk("clk2_data", 32'(out_data), 32'hFFFFFF);
      for (int x = 1; x < HT; x++) begin
         step();
         chk("line0_de", 32'(out_de), (x < 16) ? 32'h1 : 32'h0);
         chk("line0_data", 32'(out_data), (x < 16) ? 32'(bar_rgb[x / 2]) : 32'h0);
         chk("line0_hsync", 32'(out_hsync), (x == 18 || x == 19) ? 32'h0 : 32'h1);
      end

      // mid-frame CTRL/COLOR write does not affect the current frame
      wait_pix(0, 5, 1, FT);
      bus(2'd1, 1'b1, 32'h0012_3456, rd);
      bus(2'd0, 1'b1, 32'h0000_0001, rd);
      wait_pix(0, 4, 3, FT);
      chk("midframe_bar", 32'(out_data), 32'h00FFFF);
      wait_pix(0, 23, 4, FT);
      chk("vs_line4", 32'(out_vsync), 32'h1);
      wait_pix(0, 0, 5, FT);
      chk("vs_line5_start", 32'(out_vsync), 32'h0);
      wait_pix(0, 23, 5, FT);
      chk("vs_line5_end", 32'(out_vsync), 32'h0);
      wait_pix(0, 0, 6, FT);
      chk("vs_line6", 32'(out_vsync), 32'h1);
      wait_pix(1, 0, 0, FT);
      for (int i = 0; i < FT; i++) begin
         chk("solid", 32'(out_data), (o_x < 16 && o_y < 4) ? 32'h123456 : 32'h0);
         step();
      end

      // status read in vertical blanking of frame 3
      wait_pix(3, 0, 6, 3 * FT);
      chk("st_pre_ack", 32'(wb_ack), 32'h0);
      chk("st_pre_rdata", wb_rdata, 32'h0);
      wb_addr = 2'd2; wb_we = 1'b0; wb_cyc = 1'b1;
      step();
      chk("st_ack", 32'(wb_ack), 32'h1);
      chk("st_rdata", wb_rdata, 32'h0001_0003);
      step();
      chk("st_ack_low", 32'(wb_ack), 32'h0);
      chk("st_rdata_post", wb_rdata, 32'h0);
      wb_cyc = 1'b0;
      step();
      chk("st_rdata_idle", wb_rdata, 32'h0);

      // grid, then reserved mode
      bus(2'd0, 1'b1, 32'h3, rd);
      wait_pix(4, 0, 0, 2 * FT);
      chk("grid_0_0", 32'(out_data), 32'hFFFFFF);
      wait_pix(4, 5, 2, FT);
      chk("grid_5_2", 32'(out_data), 32'h0);
      wait_pix(4, 15, 2, FT);
      chk("grid_15_2", 32'(out_data), 32'hFFFFFF);
      wait_pix(4, 5, 3, FT);
      chk("grid_5_3", 32'(out_data), 32'hFFFFFF);
      bus(2'd0, 1'b1, 32'h7, rd);
      wait_pix(5, 0, 0, 2 * FT);
      for (int i = 0; i < FT; i++) begin
         chk("mode7", 32'(out_data), 32'h0);
         step();
      end

      // CSR vector table
      foreach (vecs[i]) begin
         bus(vecs[i].waddr, 1'b1, vecs[i].wdata, rd);
         bus(vecs[i].raddr, 1'b0, 32'h0, rd);
         chk($sformatf("csr%0d", i), rd, vecs[i].exp);
      end

      // randomized bus traffic across all modes
      repeat (1500) begin
         wb_cyc   = ($urandom_range(0, 5) == 0);
         wb_we    = 1'($urandom_range(0, 1));
         wb_addr  = 2'($urandom_range(0, 3));
         wb_wdata = $urandom;
         step();
      end
      wb_cyc = 1'b0; wb_we = 1'b0;

      // frame counter low byte wrap in gradient mode
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      bus(2'd0, 1'b1, 32'h2, rd);
      wait_pix(255, 0, 0, 256 * FT);
      chk("grad_f255", 32'(out_data), 32'h0000FF);
      wait_pix(256, 0, 0, 2 * FT);
      chk("grad_f256", 32'(out_data), 32'h000000);
      wait_pix(256, 3, 1, FT);
      chk("grad_3_1", 32'(out_data), 32'h030100);
      wait_pix(256, 0, 5, FT);
      bus(2'd2, 1'b0, 32'h0, rd);
      chk("st_f256", rd, 32'h0001_0100);

      // reset mid-frame during a bus write
      bus(2'd1, 1'b1, 32'h00AB_CDEF, rd);
      wait_pix(257, 9, 2, 2 * FT);
      rst = 1'b1;
      wb_addr = 2'd0; wb_we = 1'b1; wb_wdata = 32'h5; wb_cyc = 1'b1;
      step();
      chk("abort_data", 32'(out_data), 32'h0);
      chk("abort_de", 32'(out_de), 32'h0);
      chk("abort_hsync", 32'(out_hsync), 32'h1);
      chk("abort_vsync", 32'(out_vsync), 32'h1);
      chk("abort_ack", 32'(wb_ack), 32'h0);
      chk("abort_rdata", wb_rdata, 32'h0);
      rst = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
      step();
      chk("abort_clk1_de", 32'(out_de), 32'h0);
      step();
      chk("abort_clk2_de", 32'(out_de), 32'h1);
      chk("abort_clk2_data", 32'(out_data), 32'hFFFFFF);
      bus(2'd0, 1'b0, 32'h0, rd);
      chk("abort_ctrl", rd, 32'h0);
      bus(2'd1, 1'b0, 32'h0, rd);
      chk("abort_color", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
